// File: rtl/uart_tx_fifo.sv
// Byte FIFO with a drain FSM that feeds UartTx one start pulse at a time,
// honouring tx_busy and yielding the UART while tx_inhibit is high.
module uart_tx_fifo #(
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter int unsigned BUSY_WAIT  = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [7:0]            wr_data,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow,
   input  logic                  tx_inhibit,
   input  logic                  tx_busy,
   output logic                  tx_start,
   output logic [7:0]            sdata
);

   localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
   localparam int unsigned CNT_W  = DEPTH_LOG2 + 1;
   localparam int unsigned WAIT_W = $clog2(BUSY_WAIT + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT_BUSY,
      ST_WAIT_DONE
   } state_t;

   state_t                state_q;
   state_t                state_nxt;
   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q;
   logic [DEPTH_LOG2-1:0] rd_ptr_q;
   logic [WAIT_W-1:0]     wait_cnt_q;
   logic [WAIT_W-1:0]     wait_cnt_nxt;
   logic [CNT_W-1:0]      count_nxt;
   logic                  can_pop_c;
   logic                  wait_last_c;
   logic                  pop_c;
   logic                  push_c;
   logic                  drop_c;

   // A new byte may leave only when queued data exists and the UART is free and ours
   assign can_pop_c   = !empty && !tx_inhibit && !tx_busy;
   assign wait_last_c = (wait_cnt_q == WAIT_W'(BUSY_WAIT - 1));

   // A push on a full FIFO is still accepted when a pop frees a slot on the same edge
   assign push_c = wr_en && (!full || pop_c);
   assign drop_c = wr_en && full && !pop_c;

   // Drain FSM state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_nxt;
   end

   // Drain FSM next-state logic; tx_inhibit only matters before a byte is launched
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_IDLE:      if (can_pop_c) state_nxt = ST_START;
         ST_START:     state_nxt = ST_WAIT_BUSY;
         ST_WAIT_BUSY: begin
            if (tx_busy)          state_nxt = ST_WAIT_DONE;
            else if (wait_last_c) state_nxt = ST_IDLE;
         end
         ST_WAIT_DONE: if (!tx_busy) state_nxt = ST_IDLE;
         default:      state_nxt = ST_IDLE;
      endcase
   end

   // Drain FSM outputs: pop strobe and busy-wait timeout counter
   always_comb begin
      pop_c        = 1'b0;
      wait_cnt_nxt = wait_cnt_q;
      case (state_q)
         ST_IDLE:      pop_c = can_pop_c;
         ST_START:     wait_cnt_nxt = '0;
         ST_WAIT_BUSY: if (!tx_busy) wait_cnt_nxt = wait_cnt_q + WAIT_W'(1);
         default:      ;
      endcase
   end

   // Occupancy moves only when exactly one of push/pop happens
   always_comb begin
      count_nxt = count;
      case ({push_c, pop_c})
         2'b10:   count_nxt = count + CNT_W'(1);
         2'b01:   count_nxt = count - CNT_W'(1);
         default: ;
      endcase
   end

   // FIFO storage; contents need no reset
   always_ff @(posedge clock) begin
      if (push_c) mem[wr_ptr_q] <= wr_data;
   end

   // Pointers, flags, registered start pulse and output byte
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count      <= '0;
         full       <= 1'b0;
         empty      <= 1'b1;
         overflow   <= 1'b0;
         tx_start   <= 1'b0;
         sdata      <= 8'h00;
         wait_cnt_q <= '0;
      end else begin
         if (push_c) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
         if (pop_c) begin
            rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            sdata    <= mem[rd_ptr_q];
         end
         if (drop_c) overflow <= 1'b1;
         count      <= count_nxt;
         full       <= (count_nxt == CNT_W'(DEPTH));
         empty      <= (count_nxt == '0);
         tx_start   <= pop_c;
         wait_cnt_q <= wait_cnt_nxt;
      end
   end

endmodule
